// File: rtl/vlsu_pkg.sv
// Shared types and constants for the sequential load datapath front end.
package vlsu_pkg;

   // Bus geometry for the load path.
   localparam int unsigned AxiDataWidth = 128;
   localparam int unsigned AxiAddrWidth = 64;
   localparam int unsigned B            = AxiDataWidth / 8;   // bytes per beat
   localparam int unsigned busNibbles   = AxiDataWidth / 4;   // nibbles per beat
   localparam int unsigned Page4K       = 4096;
   localparam int unsigned MaxBeats     = 256;

   localparam int unsigned OffW = $clog2(B);                  // byte offset within a beat
   localparam int unsigned LbnW = $clog2(busNibbles) + 1;     // holds 0..busNibbles

   // Per-beat record handed to the sequential load controller.
   typedef struct packed {
      logic [AxiAddrWidth:0] addr;         // nibble address
      logic                  isHead;
      logic [7:0]            rmnBeat;
      logic [LbnW-1:0]       lbN;
      logic                  isFinalBeat;
   } txn_ctrl_t;

   // One issued burst, queued between AR issue and beat expansion.
   typedef struct packed {
      logic [AxiAddrWidth-1:0] addr;       // burst start byte address
      logic [7:0]              len;        // beats - 1
      logic [LbnW-1:0]         lbN;        // valid nibbles in the last beat
      logic                    is_final;   // last burst of the request
   } ld_desc_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_ISSUE
   } split_state_e;

endpackage

// File: rtl/Queue.sv
// Small synchronous FIFO; FLOW=1 lets data pass straight through when empty.
module Queue #(
   parameter int unsigned DEPTH = 4,
   parameter bit          FLOW  = 1'b0,
   parameter type         T     = logic
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic enq_valid_i,
   output logic enq_ready_o,
   input  T     enq_data_i,
   output logic deq_valid_o,
   input  logic deq_ready_i,
   output T     deq_data_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   T                mem [DEPTH];
   logic [PtrW-1:0] wr_ptr, rd_ptr;
   logic [CntW-1:0] count;
   logic            empty, full, push, pop, bypass, do_wr, do_rd;

   assign empty       = (count == '0);
   assign full        = (count == CntW'(DEPTH));
   assign enq_ready_o = !full;
   assign deq_valid_o = !empty || (FLOW && enq_valid_i);
   assign deq_data_o  = (FLOW && empty) ? enq_data_i : mem[rd_ptr];

   assign push   = enq_valid_i && enq_ready_o;
   assign pop    = deq_valid_o && deq_ready_i;
   assign bypass = FLOW && empty && push && pop;
   assign do_wr  = push && !bypass;
   assign do_rd  = pop && !bypass;

   // Pointers and occupancy; push and pop in the same cycle both take effect.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= (wr_ptr == PtrW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= (rd_ptr == PtrW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         if (do_wr && !do_rd)      count <= count + 1'b1;
         else if (do_rd && !do_wr) count <= count - 1'b1;
      end
   end

   // Storage array.
   // NOTE: the array has no reset; an entry is only read after it was written, and
   // leaving it out of reset keeps it a plain RAM.
   always_ff @(posedge clk_i) begin
      if (do_wr) mem[wr_ptr] <= enq_data_i;
   end

endmodule

// File: rtl/load_beat_expander.sv
// Expands one burst descriptor into one txn_ctrl record per R beat.
module load_beat_expander
   import vlsu_pkg::*;
(
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      desc_valid_i,
   output logic      desc_ready_o,
   input  ld_desc_t  desc_i,
   output logic      txn_ctrl_valid_o,
   input  logic      txn_ctrl_ready_i,
   output txn_ctrl_t txn_ctrl_o
);

   ld_desc_t                desc_q;
   logic                    held_q;
   logic [7:0]              k_q;
   logic [7:0]              rmn;
   logic                    last_beat, txn_fire, load;
   logic [AxiAddrWidth-1:0] beat_addr;

   assign rmn              = desc_q.len - k_q;
   assign last_beat        = (rmn == 8'd0);
   assign txn_ctrl_valid_o = rst_ni && held_q;
   assign txn_fire         = txn_ctrl_valid_o && txn_ctrl_ready_i;
   // Reload on the last beat's handshake so consecutive bursts run without a bubble.
   assign desc_ready_o     = rst_ni && (!held_q || (txn_fire && last_beat));
   assign load             = desc_valid_i && desc_ready_o;

   // Descriptor holding register and beat counter.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         desc_q <= '0;
         held_q <= 1'b0;
         k_q    <= '0;
      end else if (load) begin
         desc_q <= desc_i;
         held_q <= 1'b1;
         k_q    <= '0;
      end else if (txn_fire) begin
         if (last_beat) begin
            held_q <= 1'b0;
            k_q    <= '0;
         end else begin
            k_q <= k_q + 8'd1;
         end
      end
   end

   // Record fields: the head beat keeps the unaligned start, later beats are beat-aligned.
   always_comb begin
      beat_addr = {desc_q.addr[AxiAddrWidth-1:OffW], OffW'(0)}
                + (AxiAddrWidth'(k_q) << OffW);
      txn_ctrl_o.addr        = (k_q == 8'd0) ? {desc_q.addr, 1'b0} : {beat_addr, 1'b0};
      txn_ctrl_o.isHead      = (k_q == 8'd0);
      txn_ctrl_o.rmnBeat     = rmn;
      txn_ctrl_o.lbN         = last_beat ? desc_q.lbN : LbnW'(busNibbles);
      txn_ctrl_o.isFinalBeat = desc_q.is_final && last_beat;
   end

endmodule

// File: rtl/load_txn_ctrl_gen.sv
// Splits a contiguous load request into 4KB-safe AXI4 INCR bursts and feeds the
// per-beat expander through a descriptor FIFO, so AR issue can run ahead of R data.
module load_txn_ctrl_gen
   import vlsu_pkg::*;
#(
   parameter int unsigned ReqLenWidth = 16,
   parameter int unsigned DescDepth   = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [AxiAddrWidth-1:0] req_addr_i,
   input  logic [ReqLenWidth-1:0]  req_nbytes_i,
   output logic                    ar_valid_o,
   input  logic                    ar_ready_i,
   output logic [AxiAddrWidth-1:0] ar_addr_o,
   output logic [7:0]              ar_len_o,
   output logic [2:0]              ar_size_o,
   output logic [1:0]              ar_burst_o,
   output logic                    txn_ctrl_valid_o,
   input  logic                    txn_ctrl_ready_i,
   output txn_ctrl_t               txn_ctrl_o
);

   split_state_e            state_q, state_d;
   logic [AxiAddrWidth-1:0] cur_addr_q;
   logic [ReqLenWidth-1:0]  rem_bytes_q, burst_bytes_q;
   logic [7:0]              len_q;
   logic [LbnW-1:0]         lbn_q;
   logic                    final_q;

   logic                    req_fire, ar_fire;
   logic                    enq_ready, deq_valid, deq_ready;
   ld_desc_t                enq_desc, deq_desc;

   logic [OffW-1:0]         off_c;
   logic [31:0]             to_page_c, to_max_c, bb_c, span_c;
   logic [8:0]              beats_c;
   logic [LbnW-1:0]         lbn_c;

   assign req_fire   = req_valid_i && req_ready_o;
   assign ar_fire    = ar_valid_o && ar_ready_i;
   assign ar_addr_o  = cur_addr_q;
   assign ar_len_o   = len_q;
   assign ar_size_o  = 3'(OffW);
   assign ar_burst_o = 2'b01;

   // Splitter state register.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Splitter next-state logic.
   // NOTE: state_d gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (req_fire && (req_nbytes_i != '0)) state_d = S_CALC;
         S_CALC:  state_d = S_ISSUE;
         S_ISSUE: if (ar_fire) state_d = final_q ? S_IDLE : S_CALC;
         default: state_d = S_IDLE;
      endcase
   end

   // Splitter outputs; everything handshake-related is forced low while in reset.
   always_comb begin
      req_ready_o = rst_ni && (state_q == S_IDLE);
      ar_valid_o  = rst_ni && (state_q == S_ISSUE) && enq_ready;
   end

   // Next burst geometry: limited by remaining bytes, the 4KB page and 256 beats.
   always_comb begin
      off_c     = cur_addr_q[OffW-1:0];
      to_page_c = 32'(Page4K) - 32'(cur_addr_q[11:0]);
      to_max_c  = 32'(MaxBeats * B) - 32'(off_c);
      bb_c      = 32'(rem_bytes_q);
      if (to_page_c < bb_c) bb_c = to_page_c;
      if (to_max_c < bb_c)  bb_c = to_max_c;
      span_c    = 32'(off_c) + bb_c;
      beats_c   = 9'((span_c + 32'(B) - 32'd1) >> OffW);
      lbn_c     = LbnW'((((span_c - 32'd1) & 32'(B - 1)) + 32'd1) << 1);
   end

   // Request bookkeeping and the registered burst geometry driving AR.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cur_addr_q    <= '0;
         rem_bytes_q   <= '0;
         burst_bytes_q <= '0;
         len_q         <= '0;
         lbn_q         <= '0;
         final_q       <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: if (req_fire) begin
               cur_addr_q  <= req_addr_i;
               rem_bytes_q <= req_nbytes_i;
            end
            S_CALC: begin
               burst_bytes_q <= ReqLenWidth'(bb_c);
               len_q         <= 8'(beats_c - 9'd1);
               lbn_q         <= lbn_c;
               final_q       <= (bb_c == 32'(rem_bytes_q));
            end
            S_ISSUE: if (ar_fire) begin
               cur_addr_q  <= cur_addr_q + AxiAddrWidth'(burst_bytes_q);
               rem_bytes_q <= rem_bytes_q - burst_bytes_q;
            end
            default: ;
         endcase
      end
   end

   assign enq_desc = '{addr: cur_addr_q, len: len_q, lbN: lbn_q, is_final: final_q};

   Queue #(
      .DEPTH (DescDepth),
      .FLOW  (1'b0),
      .T     (ld_desc_t)
   ) u_desc_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .enq_valid_i (ar_fire),
      .enq_ready_o (enq_ready),
      .enq_data_i  (enq_desc),
      .deq_valid_o (deq_valid),
      .deq_ready_i (deq_ready),
      .deq_data_o  (deq_desc)
   );

   load_beat_expander u_expander (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .desc_valid_i     (deq_valid),
      .desc_ready_o     (deq_ready),
      .desc_i           (deq_desc),
      .txn_ctrl_valid_o (txn_ctrl_valid_o),
      .txn_ctrl_ready_i (txn_ctrl_ready_i),
      .txn_ctrl_o       (txn_ctrl_o)
   );

endmodule

// File: tb/tb_load_txn_ctrl_gen.sv
// Directed bench for load_txn_ctrl_gen with hand-computed expectations (B=16).
module tb_load_txn_ctrl_gen;
   import vlsu_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [63:0] req_addr_i;
   logic [15:0] req_nbytes_i;
   logic        ar_valid_o;
   logic        ar_ready_i;
   logic [63:0] ar_addr_o;
   logic [7:0]  ar_len_o;
   logic [2:0]  ar_size_o;
   logic [1:0]  ar_burst_o;
   logic        txn_ctrl_valid_o;
   logic        txn_ctrl_ready_i;
   txn_ctrl_t   txn_ctrl_o;

   always #5 clk_i = ~clk_i;

   load_txn_ctrl_gen #(.ReqLenWidth(16), .DescDepth(4)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .req_valid_i      (req_valid_i),
      .req_ready_o      (req_ready_o),
      .req_addr_i       (req_addr_i),
      .req_nbytes_i     (req_nbytes_i),
      .ar_valid_o       (ar_valid_o),
      .ar_ready_i       (ar_ready_i),
      .ar_addr_o        (ar_addr_o),
      .ar_len_o         (ar_len_o),
      .ar_size_o        (ar_size_o),
      .ar_burst_o       (ar_burst_o),
      .txn_ctrl_valid_o (txn_ctrl_valid_o),
      .txn_ctrl_ready_i (txn_ctrl_ready_i),
      .txn_ctrl_o       (txn_ctrl_o)
   );

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_rec_t;

   ar_rec_t   arq[$];
   txn_ctrl_t txq[$];
   int        total = 0;
   int        bad   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Record every AR and txn_ctrl handshake, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (ar_valid_o && ar_ready_i)
            arq.push_back('{addr: ar_addr_o, len: ar_len_o, size: ar_size_o, burst: ar_burst_o});
         if (txn_ctrl_valid_o && txn_ctrl_ready_i)
            txq.push_back(txn_ctrl_o);
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_req(input logic [63:0] a, input logic [15:0] n);
      bit done = 1'b0;
      req_valid_i  = 1'b1;
      req_addr_i   = a;
      req_nbytes_i = n;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk_i);
         if (req_ready_o) done = 1'b1;
         step();
      end
      req_valid_i = 1'b0;
      if (!done) check("req_accept_timeout", done, 1);
   endtask

   task automatic wait_txn(input string tag, input int n, input int budget);
      int c = 0;
      while (txq.size() < n && c < budget) begin
         @(negedge clk_i);
         c++;
      end
      repeat (10) step();
      check({tag, "_txn_count"}, txq.size(), n);
   endtask

   task automatic check_txn(input string t, input int i, input logic [64:0] a, input logic h,
                            input logic [7:0] r, input logic [5:0] l, input logic f);
      if (i >= txq.size()) begin
         check({t, "_present"}, txq.size(), i + 1);
         return;
      end
      check({t, "_addr"}, txq[i].addr, a);
      check({t, "_head"}, txq[i].isHead, h);
      check({t, "_rmn"},  txq[i].rmnBeat, r);
      check({t, "_lbn"},  txq[i].lbN, l);
      check({t, "_fin"},  txq[i].isFinalBeat, f);
   endtask

   task automatic check_ar(input string t, input int i, input logic [63:0] a, input logic [7:0] len);
      if (i >= arq.size()) begin
         check({t, "_present"}, arq.size(), i + 1);
         return;
      end
      check({t, "_addr"},  arq[i].addr, a);
      check({t, "_len"},   arq[i].len, len);
      check({t, "_size"},  arq[i].size, 4);
      check({t, "_burst"}, arq[i].burst, 1);
   endtask

   task automatic clear_logs();
      arq.delete();
      txq.delete();
   endtask

   initial begin
      int nfinal;
      int c;
      rst_ni           = 1'b0;
      req_valid_i      = 1'b0;
      req_addr_i       = '0;
      req_nbytes_i     = '0;
      ar_ready_i       = 1'b1;
      txn_ctrl_ready_i = 1'b1;

      // Reset state
      repeat (2) @(negedge clk_i);
      check("rst_req_ready", req_ready_o, 0);
      check("rst_ar_valid",  ar_valid_o, 0);
      check("rst_txn_valid", txn_ctrl_valid_o, 0);
      step();
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("idle_req_ready", req_ready_o, 1);
      step();

      // Single burst, unaligned start: 0x1004 + 40 bytes -> 3 beats
      send_req(64'h1004, 16'd40);
      @(negedge clk_i);
      check("t1_lat_calc_ar_valid", ar_valid_o, 0);
      @(negedge clk_i);
      check("t1_lat_issue_ar_valid", ar_valid_o, 1);
      wait_txn("t1", 3, 50);
      check("t1_ar_count", arq.size(), 1);
      check_ar("t1_ar0", 0, 64'h1004, 8'd2);
      check_txn("t1_b0", 0, 65'h2008, 1'b1, 8'd2, 6'd32, 1'b0);
      check_txn("t1_b1", 1, 65'h2020, 1'b0, 8'd1, 6'd32, 1'b0);
      check_txn("t1_b2", 2, 65'h2040, 1'b0, 8'd0, 6'd24, 1'b1);
      clear_logs();

      // Page crossing: 0x0FF8 + 32 -> 8 bytes up to 0x1000, then 24 bytes
      send_req(64'h0FF8, 16'd32);
      wait_txn("t2", 3, 50);
      check("t2_ar_count", arq.size(), 2);
      check_ar("t2_ar0", 0, 64'h0FF8, 8'd0);
      check_ar("t2_ar1", 1, 64'h1000, 8'd1);
      // bytes 0xFF8..0xFFF end at the top of the beat: lbN = 16 bytes * 2
      check_txn("t2_b0", 0, 65'h1FF0, 1'b1, 8'd0, 6'd32, 1'b0);
      check_txn("t2_b1", 1, 65'h2000, 1'b1, 8'd1, 6'd32, 1'b0);
      check_txn("t2_b2", 2, 65'h2020, 1'b0, 8'd0, 6'd16, 1'b1);
      clear_logs();

      // Two full 256-beat bursts, back to back
      send_req(64'h0, 16'd8192);
      wait_txn("t3", 512, 1500);
      check("t3_ar_count", arq.size(), 2);
      check_ar("t3_ar0", 0, 64'h0, 8'd255);
      check_ar("t3_ar1", 1, 64'h1000, 8'd255);
      for (int i = 0; i < 512; i++)
         check_txn($sformatf("t3_b%0d", i), i, 65'(i * 32), (i % 256) == 0,
                   8'(255 - (i % 256)), 6'd32, i == 511);
      clear_logs();

      // Stalls: AR held off, then consumer held off until the FIFO fills
      ar_ready_i       = 1'b0;
      txn_ctrl_ready_i = 1'b0;
      send_req(64'h0, 16'd24576);
      c = 0;
      @(negedge clk_i);
      while (!ar_valid_o && c < 10) begin
         @(negedge clk_i);
         c++;
      end
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t4_stall%0d_valid", i), ar_valid_o, 1);
         check($sformatf("t4_stall%0d_addr", i),  ar_addr_o, 64'h0);
         check($sformatf("t4_stall%0d_len", i),   ar_len_o, 8'd255);
         @(negedge clk_i);
      end
      step();
      ar_ready_i = 1'b1;
      repeat (60) step();
      @(negedge clk_i);
      // one descriptor in the expander plus four in the FIFO
      check("t4_full_ar_count", arq.size(), 5);
      check("t4_full_ar_valid", ar_valid_o, 0);
      check("t4_full_txn_valid", txn_ctrl_valid_o, 1);
      check("t4_full_txn_addr", txn_ctrl_o.addr, 65'h0);
      check("t4_full_txn_count", txq.size(), 0);
      step();
      txn_ctrl_ready_i = 1'b1;
      wait_txn("t4", 1536, 4000);
      check("t4_ar_count", arq.size(), 6);
      for (int i = 0; i < 6; i++)
         check_ar($sformatf("t4_ar%0d", i), i, 64'(i * 4096), 8'd255);
      nfinal = 0;
      foreach (txq[i]) if (txq[i].isFinalBeat) nfinal++;
      check("t4_final_count", nfinal, 1);
      check_txn("t4_b255",  255,  65'h1FE0, 1'b0, 8'd0,   6'd32, 1'b0);
      check_txn("t4_b256",  256,  65'h2000, 1'b1, 8'd255, 6'd32, 1'b0);
      check_txn("t4_b1535", 1535, 65'hBFE0, 1'b0, 8'd0,   6'd32, 1'b1);
      clear_logs();

      // Zero-length request
      send_req(64'h40, 16'd0);
      @(negedge clk_i);
      check("t5_req_ready", req_ready_o, 1);
      repeat (20) step();
      check("t5_ar_count", arq.size(), 0);
      check("t5_txn_count", txq.size(), 0);

      // Reset during beat 1 of a 3-beat burst
      txn_ctrl_ready_i = 1'b0;
      send_req(64'h1004, 16'd40);
      c = 0;
      @(negedge clk_i);
      while (!txn_ctrl_valid_o && c < 20) begin
         @(negedge clk_i);
         c++;
      end
      check("t6_beat0_valid", txn_ctrl_valid_o, 1);
      step();
      txn_ctrl_ready_i = 1'b1;
      step();
      txn_ctrl_ready_i = 1'b0;
      rst_ni           = 1'b0;
      @(negedge clk_i);
      check("t6_rst_req_ready", req_ready_o, 0);
      check("t6_rst_ar_valid",  ar_valid_o, 0);
      check("t6_rst_txn_valid", txn_ctrl_valid_o, 0);
      step();
      rst_ni           = 1'b1;
      txn_ctrl_ready_i = 1'b1;
      repeat (10) step();
      check("t6_pre_txn_count", txq.size(), 1);
      check_txn("t6_pre_b0", 0, 65'h2008, 1'b1, 8'd2, 6'd32, 1'b0);
      clear_logs();
      send_req(64'h0FF8, 16'd32);
      wait_txn("t6_post", 3, 50);
      check("t6_post_ar_count", arq.size(), 2);
      check_txn("t6_post_b0", 0, 65'h1FF0, 1'b1, 8'd0, 6'd32, 1'b0);
      check_txn("t6_post_b2", 2, 65'h2020, 1'b0, 8'd0, 6'd16, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
